// File: rtl/dyn_scan_ctrl.sv
// Time-multiplexed 4-digit display scanner with blanking dead-time
// and frame-synchronous double-buffered digit data.
module dyn_scan_ctrl #(
    parameter int DIV   = 50000,
    parameter int BLANK = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] data_in,
    input  logic [3:0]  en_mask,
    output logic [1:0]  addr,
    output logic [3:0]  an,
    output logic [3:0]  din0,
    output logic [3:0]  din1,
    output logic [3:0]  din2,
    output logic [3:0]  din3,
    output logic        pending,
    output logic        frame_tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
    localparam logic [CW-1:0] BLANK_C = CW'(BLANK);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    addr_q, addr_d;
    logic [15:0]   shadow_q, shadow_d;
    logic [15:0]   din_q, din_d;
    logic          pending_q, pending_d;
    logic          tick_q, tick_d;
    logic          boundary;
    logic          an_on;

    always_comb begin
        cnt_d     = cnt_q + CW'(1);
        addr_d    = addr_q;
        shadow_d  = shadow_q;
        din_d     = din_q;
        pending_d = pending_q;
        boundary  = (addr_q == 2'd3) && (cnt_q == CNT_MAX);
        tick_d    = boundary;
        if (cnt_q == CNT_MAX) begin
            cnt_d  = '0;
            addr_d = addr_q + 2'd1;
        end
        // Pending data lands first so a coincident load queues for next frame.
        if (boundary && pending_q) begin
            din_d     = shadow_q;
            pending_d = 1'b0;
        end
        if (load) begin
            shadow_d  = data_in;
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            addr_q    <= 2'd0;
            shadow_q  <= 16'h0000;
            din_q     <= 16'h0000;
            pending_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            shadow_q  <= shadow_d;
            din_q     <= din_d;
            pending_q <= pending_d;
            tick_q    <= tick_d;
        end
    end

    always_comb begin
        an_on = (cnt_q >= BLANK_C) && en_mask[addr_q];
        an    = an_on ? ~(4'b0001 << addr_q) : 4'b1111;
    end

    assign addr       = addr_q;
    assign din0       = din_q[3:0];
    assign din1       = din_q[7:4];
    assign din2       = din_q[11:8];
    assign din3       = din_q[15:12];
    assign pending    = pending_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_dyn_scan_ctrl.sv
// Directed bench for dyn_scan_ctrl at DIV=4, BLANK=1.
module tb_dyn_scan_ctrl;

    logic        clk;
    logic        rst;
    logic        load;
    logic [15:0] data_in;
    logic [3:0]  en_mask;
    logic [1:0]  addr;
    logic [3:0]  an;
    logic [3:0]  din0, din1, din2, din3;
    logic        pending;
    logic        frame_tick;

    int total = 0;
    int bad   = 0;
    int pos   = 0;

    dyn_scan_ctrl #(.DIV(4), .BLANK(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .data_in    (data_in),
        .en_mask    (en_mask),
        .addr       (addr),
        .an         (an),
        .din0       (din0),
        .din1       (din1),
        .din2       (din2),
        .din3       (din3),
        .pending    (pending),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h pos=%0d", tag, obs, exp, pos);
        end
    endtask

    task automatic chk_din(input string tag, input logic [15:0] exp);
        chk(tag, {din3, din2, din1, din0}, exp);
    endtask

    // Advance one clock; position within the 16-cycle frame tracks along.
    task automatic tick();
        @(posedge clk);
        #1;
        pos = (pos + 1) % 16;
    endtask

    task automatic adv(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic run_frame(input logic [3:0] mask, input logic tick0);
        logic [3:0] exp_an;
        logic [3:0] one;
        en_mask = mask;
        for (int k = 0; k < 16; k++) begin
            one = 4'b0001 << (k / 4);
            exp_an = ((k % 4) >= 1 && mask[k/4]) ? ~one : 4'b1111;
            chk("addr", 16'(addr), 16'(k / 4));
            chk("an", 16'(an), 16'(exp_an));
            chk("frame_tick", 16'(frame_tick), (k == 0) ? 16'(tick0) : 16'h0);
            tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        load = 1'b0;
        data_in = 16'h0000;
        en_mask = 4'b1111;
        @(posedge clk);
        #1;
        pos = 0;
        chk("rst_addr", 16'(addr), 16'h0);
        chk("rst_an", 16'(an), 16'hf);
        chk_din("rst_din", 16'h0000);
        chk("rst_pending", 16'(pending), 16'h0);
        chk("rst_tick", 16'(frame_tick), 16'h0);
        rst = 1'b0;

        run_frame(4'b1111, 1'b0);

        // Single mid-frame load
        chk("tick_f2", 16'(frame_tick), 16'h1);
        adv(5);
        load = 1'b1;
        data_in = 16'h1234;
        tick();
        load = 1'b0;
        chk("ld_pending", 16'(pending), 16'h1);
        chk_din("ld_hold", 16'h0000);
        adv(9);
        chk_din("ld_hold_bnd", 16'h0000);
        chk("ld_pending_bnd", 16'(pending), 16'h1);
        tick();
        chk_din("ld_xfer", 16'h1234);
        chk("ld_pending_clr", 16'(pending), 16'h0);
        chk("ld_tick", 16'(frame_tick), 16'h1);

        // Overwritten shadow: only the last value shows
        adv(2);
        load = 1'b1;
        data_in = 16'hAAAA;
        tick();
        load = 1'b0;
        adv(6);
        load = 1'b1;
        data_in = 16'h5B0F;
        tick();
        load = 1'b0;
        while (pos != 0) begin
            chk_din("ow_hold", 16'h1234);
            tick();
        end
        chk_din("ow_xfer", 16'h5B0F);
        chk("ow_pending", 16'(pending), 16'h0);

        // Load coincident with boundary
        adv(3);
        load = 1'b1;
        data_in = 16'h1111;
        tick();
        load = 1'b0;
        adv(11);
        load = 1'b1;
        data_in = 16'h2222;
        tick();
        load = 1'b0;
        chk_din("bl_first", 16'h1111);
        chk("bl_pending", 16'(pending), 16'h1);
        adv(16);
        chk_din("bl_second", 16'h2222);
        chk("bl_pending_clr", 16'(pending), 16'h0);

        // Digit masking
        run_frame(4'b0101, 1'b1);
        run_frame(4'b0101, 1'b1);
        en_mask = 4'b1111;

        // Reset mid-frame with data pending
        adv(1);
        load = 1'b1;
        data_in = 16'h1234;
        tick();
        load = 1'b0;
        adv(14);
        chk_din("rs_pre", 16'h1234);
        adv(3);
        load = 1'b1;
        data_in = 16'h5678;
        tick();
        load = 1'b0;
        adv(5);
        chk("rs_pre_addr", 16'(addr), 16'h2);
        chk("rs_pre_pending", 16'(pending), 16'h1);
        rst = 1'b1;
        load = 1'b1;
        data_in = 16'hFFFF;
        tick();
        pos = 0;
        rst = 1'b0;
        load = 1'b0;
        chk("rs_addr", 16'(addr), 16'h0);
        chk("rs_an", 16'(an), 16'hf);
        chk_din("rs_din", 16'h0000);
        chk("rs_pending", 16'(pending), 16'h0);
        chk("rs_tick", 16'(frame_tick), 16'h0);
        run_frame(4'b1111, 1'b0);
        chk_din("rs_no_stale", 16'h0000);
        chk("rs_tick_after", 16'(frame_tick), 16'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
